// File: rtl/booth_mult_param.sv
// Sequential radix-2 Booth multiplier, one iteration per clock, with start/busy/fin handshake.
// Operands are extended to WIDTH+1 bits so signed and unsigned modes share the same datapath.
module booth_mult_param #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CW    = $clog2(WIDTH + 2)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 signed_mode,
  input  logic [WIDTH-1:0]     M1,
  input  logic [WIDTH-1:0]     Q1,
  output logic [2*WIDTH-1:0]   resultado,
  output logic                 busy,
  output logic                 fin
);

  localparam int unsigned E = WIDTH + 1;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e             r_state_q, w_state_d;
  logic [E-1:0]       r_a, r_q, r_m;
  logic               r_q1;
  logic [CW-1:0]      r_cnt;
  logic [2*WIDTH-1:0] r_res;

  logic [E-1:0]       w_ext_m, w_ext_q, w_sum, w_a_sh, w_q_sh;
  logic [2*WIDTH-1:0] w_prod;
  logic               w_last;

  assign w_ext_m = signed_mode ? {M1[WIDTH-1], M1} : {1'b0, M1};
  assign w_ext_q = signed_mode ? {Q1[WIDTH-1], Q1} : {1'b0, Q1};

  always_comb begin
    w_sum = r_a;
    unique case ({r_q[0], r_q1})
      2'b01:   w_sum = r_a + r_m;
      2'b10:   w_sum = r_a - r_m;
      default: w_sum = r_a;
    endcase
  end

  // Arithmetic shift of {A,Q,q_1}; the product lives in the low 2*WIDTH bits of {A,Q}.
  assign w_a_sh = {w_sum[E-1], w_sum[E-1:1]};
  assign w_q_sh = {w_sum[0], r_q[E-1:1]};
  assign w_prod = {w_a_sh[WIDTH-2:0], w_q_sh};
  assign w_last = (r_cnt == CW'(1));

  always_comb begin
    w_state_d = r_state_q;
    unique case (r_state_q)
      StIdle:  if (start) w_state_d = StRun;
      StRun:   if (w_last) w_state_d = StDone;
      StDone:  w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state_q <= StIdle;
      r_a       <= '0;
      r_q       <= '0;
      r_m       <= '0;
      r_q1      <= 1'b0;
      r_cnt     <= '0;
      r_res     <= '0;
    end else begin
      r_state_q <= w_state_d;
      if (r_state_q == StIdle && start) begin
        r_a   <= '0;
        r_q   <= w_ext_q;
        r_m   <= w_ext_m;
        r_q1  <= 1'b0;
        r_cnt <= CW'(E);
      end else if (r_state_q == StRun) begin
        r_a   <= w_a_sh;
        r_q   <= w_q_sh;
        r_q1  <= r_q[0];
        r_cnt <= r_cnt - CW'(1);
        if (w_last) r_res <= w_prod;
      end
    end
  end

  assign resultado = r_res;
  assign busy      = (r_state_q == StRun);
  assign fin       = (r_state_q == StDone);

endmodule

// File: tb/tb_booth_mult_param.sv
// Bench for booth_mult_param: WIDTH=8 and WIDTH=3 instances, directed plus random operands
// checked against plain integer multiplication.
module tb_booth_mult_param;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        st8, sm8, st3, sm3;
  logic [7:0]  m8, q8;
  logic [2:0]  m3, q3;
  logic [15:0] res8;
  logic [5:0]  res3;
  logic        busy8, fin8, busy3, fin3;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  booth_mult_param #(.WIDTH(8)) u_dut8 (
    .clk(clk), .reset(rst_n), .start(st8), .signed_mode(sm8), .M1(m8), .Q1(q8),
    .resultado(res8), .busy(busy8), .fin(fin8)
  );

  booth_mult_param #(.WIDTH(3)) u_dut3 (
    .clk(clk), .reset(rst_n), .start(st3), .signed_mode(sm3), .M1(m3), .Q1(q3),
    .resultado(res3), .busy(busy3), .fin(fin3)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Exact product of two w-bit operands, reduced to 2*w bits.
  function automatic logic [31:0] model(input int w, input logic sm, input logic [7:0] m,
                                        input logic [7:0] q);
    longint mi, qi, p;
    mi = longint'(m) & ((64'sd1 << w) - 1);
    qi = longint'(q) & ((64'sd1 << w) - 1);
    if (sm && mi >= (64'sd1 << (w - 1))) mi -= (64'sd1 << w);
    if (sm && qi >= (64'sd1 << (w - 1))) qi -= (64'sd1 << w);
    p = (mi * qi) & ((64'sd1 << (2 * w)) - 1);
    return 32'(p);
  endfunction

  task automatic drive(input int w, input logic s, input logic sm, input logic [7:0] m,
                       input logic [7:0] q);
    if (w == 8) begin
      st8 = s; sm8 = sm; m8 = m; q8 = q;
    end else begin
      st3 = s; sm3 = sm; m3 = m[2:0]; q3 = q[2:0];
    end
  endtask

  function automatic logic fin_of(input int w);
    return (w == 8) ? fin8 : fin3;
  endfunction

  function automatic logic busy_of(input int w);
    return (w == 8) ? busy8 : busy3;
  endfunction

  function automatic logic [31:0] res_of(input int w);
    return (w == 8) ? 32'(res8) : 32'(res3);
  endfunction

  // One operation; with hold=1, start stays high and operands are scrambled mid-run.
  task automatic op(input int w, input logic sm, input logic [7:0] m, input logic [7:0] q,
                    input logic [31:0] exp, input bit hold, input string tag);
    int   cyc;
    logic busy_ok;
    cyc = 0;
    busy_ok = 1'b1;
    @(negedge clk);
    drive(w, 1'b1, sm, m, q);
    @(posedge clk); #1;
    if (!hold) drive(w, 1'b0, sm, m, q);
    while (!fin_of(w) && cyc < 40) begin
      if (!busy_of(w)) busy_ok = 1'b0;
      if (hold && cyc == 2) drive(w, 1'b1, ~sm, m ^ 8'hA5, q ^ 8'h3C);
      @(posedge clk); #1;
      cyc++;
    end
    check({tag, "_latency"}, cyc, w + 1);
    check({tag, "_busy_run"}, busy_ok, 1'b1);
    check({tag, "_fin"}, fin_of(w), 1'b1);
    check({tag, "_busy_done"}, busy_of(w), 1'b0);
    check({tag, "_result"}, res_of(w), exp);
    @(posedge clk); #1;
    check({tag, "_fin_one_cycle"}, fin_of(w), 1'b0);
    check({tag, "_idle_after_done"}, busy_of(w), 1'b0);
    if (hold) begin
      drive(w, 1'b0, sm, m, q);
      @(posedge clk); #1;
      check({tag, "_stay_idle"}, busy_of(w), 1'b0);
      check({tag, "_result_held"}, res_of(w), exp);
    end
  endtask

  initial begin
    logic       sm, seen_fin;
    logic [7:0] m, q;

    rst_n = 1'b0;
    drive(8, 1'b0, 1'b0, 8'h00, 8'h00);
    drive(3, 1'b0, 1'b0, 8'h00, 8'h00);
    #1;
    check("reset_busy8", busy8, 1'b0);
    check("reset_fin8", fin8, 1'b0);
    check("reset_res8", res8, 16'h0000);
    check("reset_res3", res3, 6'h00);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    op(8, 1'b1, 8'hFD, 8'h05, 32'hFFF1, 1'b0, "s_m3x5");
    op(8, 1'b0, 8'hFF, 8'hFF, 32'hFE01, 1'b0, "u_ffxff");
    op(8, 1'b1, 8'hFF, 8'hFF, 32'h0001, 1'b0, "s_ffxff");
    op(8, 1'b1, 8'h80, 8'h80, 32'h4000, 1'b0, "s_minxmin");
    op(8, 1'b1, 8'h80, 8'h7F, 32'hC080, 1'b0, "s_minxmax");
    op(3, 1'b1, 8'h03, 8'h04, 32'h34, 1'b0, "w3_3xm4");
    op(3, 1'b1, 8'h00, 8'h04, 32'h00, 1'b0, "w3_zero");
    op(8, 1'b1, 8'h12, 8'hF3, model(8, 1'b1, 8'h12, 8'hF3), 1'b1, "hold_start");
    op(8, 1'b0, 8'hC8, 8'h0B, 32'h0898, 1'b0, "back_to_back");

    for (int i = 0; i < 20; i++) begin
      sm = 1'($urandom);
      m  = 8'($urandom);
      q  = 8'($urandom);
      op(8, sm, m, q, model(8, sm, m, q), 1'b0, "rand8");
    end
    for (int i = 0; i < 10; i++) begin
      sm = 1'($urandom);
      m  = 8'($urandom_range(0, 7));
      q  = 8'($urandom_range(0, 7));
      op(3, sm, m, q, model(3, sm, m, q), 1'b0, "rand3");
    end

    // Abort three cycles into a run.
    @(negedge clk);
    drive(8, 1'b1, 1'b1, 8'h55, 8'h66);
    @(posedge clk); #1;
    drive(8, 1'b0, 1'b1, 8'h55, 8'h66);
    repeat (3) @(posedge clk);
    #2;
    check("abort_busy_before", busy8, 1'b1);
    rst_n = 1'b0;
    #1;
    check("abort_busy", busy8, 1'b0);
    check("abort_fin", fin8, 1'b0);
    check("abort_res", res8, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;
    seen_fin = 1'b0;
    repeat (15) begin
      @(posedge clk); #1;
      seen_fin = seen_fin | fin8 | busy8;
    end
    check("abort_no_fin", seen_fin, 1'b0);
    op(8, 1'b0, 8'h07, 8'h06, 32'h002A, 1'b0, "after_abort");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/booth_mult_param.md
Name: booth_mult_param

Overview:
Parametrised sequential radix-2 Booth multiplier. It is the generalised successor to the team's fixed 3-bit Booth datapath and control-unit pair. It adds configurable operand width, a start/busy/fin handshake, operand latching, and a selectable signed/unsigned mode. The block sits beside the CPU datapath as a multi-cycle multiply unit, one Booth iteration per clock.

Parameters:
WIDTH, 8, operand width in bits (>= 2); product is 2*WIDTH bits
CW, $clog2(WIDTH+2), iteration counter width (derived, not overridden)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
start  input  1  request; sampled only in IDLE
signed_mode  input  1  1 = two's-complement operands, 0 = unsigned; latched with start
M1  input  WIDTH  multiplicand; latched with start
Q1  input  WIDTH  multiplier; latched with start
resultado  output  2*WIDTH  product, registered, held until next completion
busy  output  1  high while iterating
fin  output  1  one-cycle completion pulse

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; A, Q, M, q_1, counter cleared; resultado=0, busy=0, fin=0.
- Internal width: E = WIDTH+1.
  - M and Q are E-bit registers holding M1/Q1 extended to E bits: sign-extended if signed_mode=1, zero-extended if 0.
  - A is E bits; q_1 is 1 bit.
- States: IDLE, RUN, DONE.
- IDLE:
  - busy=0, fin=0.
  - On start=1 at an edge: load A=0, Q=ext(Q1), M=ext(M1), q_1=0, counter=E; go to RUN.
  - With start=0, remain in IDLE.
- RUN (busy=1), each edge performs one iteration:
  - {Q[0],q_1}=01: A=A+M; 10: A=A-M; 00/11: A unchanged.
  - Then arithmetic shift right of {A,Q,q_1} by one: A MSB replicated.
  - Counter decrements.
  - Add/subtract is E bits, no overflow possible: M is never -2^(E-1), because it is an extended WIDTH-bit value.
  - On the edge that performs iteration E (counter 1 to 0): go to DONE and register resultado = low 2*WIDTH bits of the post-shift {A,Q}.
- DONE:
  - fin=1, busy=0, for exactly one cycle; unconditionally return to IDLE.
  - start in DONE is ignored.
- Latency: start sampled at edge 0; resultado updated and fin high after edge E (=WIDTH+1); next start accepted at edge E+2 onward.
- start, M1, Q1, signed_mode changes during RUN/DONE are ignored; the latched values are used.
- Result correctness:
  - Exact 2*WIDTH-bit product in both modes.
  - Signed mode range is -2^(WIDTH-1) to 2^(WIDTH-1)-1 per operand, including most-negative times most-negative.
- Reset asserted mid-RUN aborts immediately to IDLE.
  - resultado clears to 0; no fin pulse is generated.
  - Operation restarts only on a new start.
- resultado is stable between completions; it never shows partial products.

Test Plan:
- WIDTH=8, signed_mode=1, M1=8'hFD (-3), Q1=8'h05 -> fin exactly 9 edges after start edge, resultado=16'hFFF1, busy high for 9 cycles.
- WIDTH=8, signed_mode=0, M1=8'hFF, Q1=8'hFF -> resultado=16'hFE01; same operands with signed_mode=1 -> 16'h0001.
- WIDTH=8, signed_mode=1, M1=Q1=8'h80 -> resultado=16'h4000; M1=8'h80, Q1=8'h7F -> 16'hC080.
- WIDTH=3, signed_mode=1, M1=3'b011, Q1=3'b100 -> resultado=6'b110100 after 4 edges (legacy-width regression); also M1=0 -> resultado=0.
- Start held high through RUN with M1/Q1 changed mid-operation -> single fin pulse, result from first operands; second op starts only from IDLE; back-to-back ops give independent correct results.
- reset=0 asserted 3 cycles into a WIDTH=8 operation -> busy, fin, resultado = 0 immediately; no fin follows; next start computes 7*6 = 16'h002A correctly.
